// File: rtl/plru_controller_if.sv
// Request/response and flush handshake between a cache front end and plru_controller.
interface plru_controller_if #(
    parameter int S_INDEX = 4,
    parameter int WAYS    = 4
);
    localparam int WAY_W = $clog2(WAYS);

    logic               req_valid;
    logic               req_ready;
    logic [S_INDEX-1:0] req_set;
    logic               req_hit;
    logic [WAY_W-1:0]   req_hit_way;
    logic               resp_valid;
    logic [S_INDEX-1:0] resp_set;
    logic [WAY_W-1:0]   resp_way;
    logic               resp_miss;
    logic               flush_req;
    logic               flush_busy;
    logic               flush_done;

    modport master (
        output req_valid, req_set, req_hit, req_hit_way, flush_req,
        input  req_ready, resp_valid, resp_set, resp_way, resp_miss,
        input  flush_busy, flush_done
    );

    modport slave (
        input  req_valid, req_set, req_hit, req_hit_way, flush_req,
        output req_ready, resp_valid, resp_set, resp_way, resp_miss,
        output flush_busy, flush_done
    );
endinterface

// File: rtl/plru_controller.sv
// Tree-PLRU controller: read set bits on port 0, report victim/touched way, write back on port 1.
// Optional PLRU_STATS_EN adds saturating hit/miss counters.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RUN   | accept one access per cycle, S1 writes back the update
// ST_DRAIN | one bubble cycle before flushing, no new accepts
// ST_FLUSH | zero one set per cycle, down-counter hits 0 on the last set
module plru_controller #(
    parameter int S_INDEX = 4,
    parameter int WAYS    = 4,
    parameter int WIDTH   = WAYS - 1
) (
    input  logic               clk,
    input  logic               rst,
    plru_controller_if.slave   bus,
    output logic               lru_csb0,
    output logic               lru_web0,
    output logic [S_INDEX-1:0] lru_addr0,
    output logic [WIDTH-1:0]   lru_din0,
    input  logic [WIDTH-1:0]   lru_dout0,
    output logic               lru_csb1,
    output logic               lru_web1,
    output logic [S_INDEX-1:0] lru_addr1,
    output logic [WIDTH-1:0]   lru_din1
`ifdef PLRU_STATS_EN
    ,
    output logic [31:0]        hit_count,
    output logic [31:0]        miss_count
`endif
);
    localparam int WAY_W = $clog2(WAYS);
    localparam logic [S_INDEX-1:0] CNT_ONE = {{(S_INDEX-1){1'b0}}, 1'b1};

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    function automatic logic [WAY_W-1:0] f_victim(input logic [WIDTH-1:0] bits);
        int               node;
        logic [WAY_W-1:0] way;
        node = 0;
        way  = '0;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            way[WAY_W-1-lvl] = bits[node];
            node = 2 * node + 1 + int'(bits[node]);
        end
        return way;
    endfunction

    // Every node on the way's path is pointed at the opposite subtree.
    function automatic logic [WIDTH-1:0] f_touch(input logic [WIDTH-1:0] bits,
                                                 input logic [WAY_W-1:0] way);
        int               node;
        logic             b;
        logic [WIDTH-1:0] res;
        node = 0;
        res  = bits;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            b         = way[WAY_W-1-lvl];
            res[node] = ~b;
            node      = 2 * node + 1 + int'(b);
        end
        return res;
    endfunction

    logic [1:0]         r_state;
    logic               r_s1_valid;
    logic [S_INDEX-1:0] r_s1_set;
    logic               r_s1_hit;
    logic [WAY_W-1:0]   r_s1_way;
    logic [S_INDEX-1:0] r_flush_left;

    logic               w_run;
    logic               w_accept;
    logic               w_flushing;
    logic               w_last;
    logic [WAY_W-1:0]   w_way;
    logic [WIDTH-1:0]   w_touch;

    assign w_run      = (r_state == ST_RUN);
    assign w_accept   = w_run && !bus.flush_req && bus.req_valid;
    assign w_flushing = (r_state == ST_FLUSH);
    assign w_last     = w_flushing && (r_flush_left == '0);
    assign w_way      = r_s1_hit ? r_s1_way : f_victim(lru_dout0);
    assign w_touch    = f_touch(lru_dout0, w_way);

    assign bus.req_ready  = w_run && !bus.flush_req;
    assign bus.resp_valid = r_s1_valid;
    assign bus.resp_set   = r_s1_set;
    assign bus.resp_way   = w_way;
    assign bus.resp_miss  = !r_s1_hit;
    assign bus.flush_busy = w_flushing;
    assign bus.flush_done = w_last;

    assign lru_csb0  = !w_accept;
    assign lru_web0  = 1'b1;
    assign lru_addr0 = w_accept ? bus.req_set : '0;
    assign lru_din0  = '0;

    // S1 and flush writes never overlap: nothing is accepted in DRAIN or FLUSH.
    assign lru_csb1  = !(r_s1_valid || w_flushing);
    assign lru_web1  = !(r_s1_valid || w_flushing);
    assign lru_addr1 = w_flushing ? ~r_flush_left : r_s1_set;
    assign lru_din1  = w_flushing ? '0 : w_touch;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_RUN;
            r_s1_valid   <= 1'b0;
            r_s1_set     <= '0;
            r_s1_hit     <= 1'b0;
            r_s1_way     <= '0;
            r_flush_left <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_set <= bus.req_set;
                r_s1_hit <= bus.req_hit;
                r_s1_way <= bus.req_hit_way;
            end
            case (r_state)
                ST_RUN: begin
                    if (bus.flush_req) r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    r_flush_left <= '1;
                    r_state      <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    if (r_flush_left == '0) r_state <= ST_RUN;
                    else r_flush_left <= r_flush_left - CNT_ONE;
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

`ifdef PLRU_STATS_EN
    always_ff @(posedge clk) begin
        if (rst || (w_run && bus.flush_req)) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (r_s1_valid) begin
            if (r_s1_hit && (hit_count != 32'hFFFF_FFFF))
                hit_count <= hit_count + 32'd1;
            if (!r_s1_hit && (miss_count != 32'hFFFF_FFFF))
                miss_count <= miss_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_plru_controller.sv
// Directed bench for plru_controller with a behavioural dual-port PLRU array.
module tb_plru_controller;
    logic       clk = 1'b0;
    logic       rst;
    logic       lru_csb0, lru_web0, lru_csb1, lru_web1;
    logic [3:0] lru_addr0, lru_addr1;
    logic [2:0] lru_din0, lru_din1, lru_dout0;
`ifdef PLRU_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif
    logic [2:0] mem [16];

    int n_tests = 0;
    int n_fail  = 0;

    plru_controller_if #(.S_INDEX(4), .WAYS(4)) bus ();

    plru_controller #(.S_INDEX(4), .WAYS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .lru_csb0  (lru_csb0),
        .lru_web0  (lru_web0),
        .lru_addr0 (lru_addr0),
        .lru_din0  (lru_din0),
        .lru_dout0 (lru_dout0),
        .lru_csb1  (lru_csb1),
        .lru_web1  (lru_web1),
        .lru_addr1 (lru_addr1),
        .lru_din1  (lru_din1)
`ifdef PLRU_STATS_EN
        ,
        .hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    // Array: registered ports, reset clears, port 0 forwards a same-address port 1 write.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= 3'b000;
            lru_dout0 <= 3'b000;
        end else begin
            if (!lru_csb1 && !lru_web1) mem[lru_addr1] <= lru_din1;
            if (!lru_csb0)
                lru_dout0 <= (!lru_csb1 && !lru_web1 && lru_addr1 == lru_addr0) ? lru_din1 : mem[lru_addr0];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] set, input logic hit,
                         input logic [1:0] way, input logic fl);
        bus.req_valid   = v;
        bus.req_set     = set;
        bus.req_hit     = hit;
        bus.req_hit_way = way;
        bus.flush_req   = fl;
        #1;
    endtask

    task automatic chk_resp(input string tag, input logic [3:0] set, input logic miss,
                            input logic [1:0] way, input logic [2:0] din);
        chk({tag, "_valid"}, 32'(bus.resp_valid), 1);
        chk({tag, "_set"},   32'(bus.resp_set), 32'(set));
        chk({tag, "_miss"},  32'(bus.resp_miss), 32'(miss));
        chk({tag, "_way"},   32'(bus.resp_way), 32'(way));
        chk({tag, "_we"},    32'({lru_csb1, lru_web1}), 0);
        chk({tag, "_addr1"}, 32'(lru_addr1), 32'(set));
        chk({tag, "_din1"},  32'(lru_din1), 32'(din));
    endtask

    logic [1:0] miss_way [4] = '{2'd0, 2'd2, 2'd1, 2'd3};
    logic [2:0] miss_din [4] = '{3'b011, 3'b110, 3'b101, 3'b000};
    logic [3:0] il_set   [4] = '{4'd1, 4'd2, 4'd1, 4'd2};
    logic [1:0] il_way   [4] = '{2'd0, 2'd0, 2'd2, 2'd2};
    logic [2:0] il_din   [4] = '{3'b011, 3'b011, 3'b110, 3'b110};

    initial begin
        rst = 1'b1;
        drive(1'b0, 4'd0, 1'b0, 2'd0, 1'b0);
        repeat (3) tick();
        chk("rst_resp_valid", 32'(bus.resp_valid), 0);
        chk("rst_flush_busy", 32'(bus.flush_busy), 0);
        chk("rst_flush_done", 32'(bus.flush_done), 0);
        chk("rst_csb0", 32'(lru_csb0), 1);
        chk("rst_web0", 32'(lru_web0), 1);
        chk("rst_csb1", 32'(lru_csb1), 1);
        chk("rst_web1", 32'(lru_web1), 1);
        rst = 1'b0;
        tick();
        chk("idle_ready", 32'(bus.req_ready), 1);

        // Four back-to-back misses to set 5 exercise read-after-write forwarding.
        drive(1'b1, 4'd5, 1'b0, 2'd0, 1'b0);
        chk("ms_ready", 32'(bus.req_ready), 1);
        chk("ms_csb0", 32'(lru_csb0), 0);
        chk("ms_addr0", 32'(lru_addr0), 5);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(i < 3, 4'd5, 1'b0, 2'd0, 1'b0);
            chk_resp($sformatf("ms%0d", i), 4'd5, 1'b1, miss_way[i], miss_din[i]);
            tick();
        end
        chk("ms_idle_valid", 32'(bus.resp_valid), 0);
        chk("ms_idle_csb1", 32'(lru_csb1), 1);

        drive(1'b1, 4'd3, 1'b1, 2'd2, 1'b0);
        tick();
        drive(1'b0, 4'd0, 1'b0, 2'd0, 1'b0);
        chk_resp("hit", 4'd3, 1'b0, 2'd2, 3'b100);
        tick();

        drive(1'b1, il_set[0], 1'b0, 2'd0, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(i < 3, il_set[(i + 1) % 4], 1'b0, 2'd0, 1'b0);
            chk_resp($sformatf("il%0d", i), il_set[i], 1'b1, il_way[i], il_din[i]);
            tick();
        end

        // Flush raised the cycle after a miss is accepted; requests stay asserted.
        drive(1'b1, 4'd5, 1'b0, 2'd0, 1'b0);
        chk("fl_acc_ready", 32'(bus.req_ready), 1);
        tick();
        drive(1'b1, 4'd7, 1'b0, 2'd0, 1'b1);
        chk_resp("fl_pre", 4'd5, 1'b1, 2'd0, 3'b011);
        chk("fl_req_ready", 32'(bus.req_ready), 0);
        chk("fl_req_csb0", 32'(lru_csb0), 1);
        tick();
        drive(1'b1, 4'd7, 1'b0, 2'd0, 1'b0);
        chk("dr_ready", 32'(bus.req_ready), 0);
        chk("dr_csb0", 32'(lru_csb0), 1);
        chk("dr_csb1", 32'(lru_csb1), 1);
        tick();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 4'd7, 1'b0, 2'd0, (i >= 3 && i <= 5));
            chk($sformatf("fl%0d_we", i), 32'({lru_csb1, lru_web1}), 0);
            chk($sformatf("fl%0d_addr1", i), 32'(lru_addr1), i);
            chk($sformatf("fl%0d_din1", i), 32'(lru_din1), 0);
            chk($sformatf("fl%0d_busy", i), 32'(bus.flush_busy), 1);
            chk($sformatf("fl%0d_done", i), 32'(bus.flush_done), (i == 15) ? 1 : 0);
            chk($sformatf("fl%0d_ready", i), 32'(bus.req_ready), 0);
            chk($sformatf("fl%0d_csb0", i), 32'(lru_csb0), 1);
            tick();
        end
        drive(1'b1, 4'd5, 1'b0, 2'd0, 1'b0);
        chk("post_fl_ready", 32'(bus.req_ready), 1);
        chk("post_fl_busy", 32'(bus.flush_busy), 0);
        chk("post_fl_done", 32'(bus.flush_done), 0);
        tick();
        drive(1'b0, 4'd0, 1'b0, 2'd0, 1'b0);
        chk_resp("post_fl", 4'd5, 1'b1, 2'd0, 3'b011);
        tick();

        drive(1'b0, 4'd0, 1'b0, 2'd0, 1'b1);
        tick();
        drive(1'b0, 4'd0, 1'b0, 2'd0, 1'b0);
        tick();
        for (int i = 0; i < 7; i++) tick();
        chk("rmf_addr1", 32'(lru_addr1), 7);
        chk("rmf_busy", 32'(bus.flush_busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rmf_csb1", 32'(lru_csb1), 1);
        chk("rmf_busy_clr", 32'(bus.flush_busy), 0);
        chk("rmf_ready", 32'(bus.req_ready), 1);
        chk("rmf_done", 32'(bus.flush_done), 0);
        tick();
        chk("rmf_csb1_next", 32'(lru_csb1), 1);

`ifdef PLRU_STATS_EN
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 4'd9, (i < 3), 2'(i), 1'b0);
            tick();
        end
        drive(1'b0, 4'd0, 1'b0, 2'd0, 1'b0);
        tick();
        chk("st_hits", hit_count, 3);
        chk("st_misses", miss_count, 2);
        drive(1'b0, 4'd0, 1'b0, 2'd0, 1'b1);
        tick();
        drive(1'b0, 4'd0, 1'b0, 2'd0, 1'b0);
        chk("st_hits_clr", hit_count, 0);
        chk("st_misses_clr", miss_count, 0);
        repeat (18) tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
